// File: rtl/display_pkg.sv
// Shared constants and the leading-zero blanking rule for the 7-segment scanner.
// Combinational helpers only; no state.
package display_pkg;

  localparam int N_DIGITS_DEF = 4;
  localparam int MAX_DIGITS   = 16;

  localparam logic [N_DIGITS_DEF-1:0] ANODE_OFF = '1;

  // Arguments are zero-extended to MAX_DIGITS, so "all higher digits zero" holds
  // for any scanner narrower than MAX_DIGITS.
  function automatic logic f_digit_blank(input logic [4*MAX_DIGITS-1:0] value,
                                         input logic [MAX_DIGITS-1:0]   mask,
                                         input int                      i);
    logic blank;
    blank = (i != 0);
    for (int k = 1; k < MAX_DIGITS; k++) begin
      if (k >= i && (value[4*k +: 4] != 4'h0 || mask[k])) begin
        blank = 1'b0;
      end
    end
    return blank;
  endfunction

endpackage

// File: rtl/display_scan_mux_tick.sv
// Slot prescaler: cnt runs 0..PRESCALE-1 while enabled, holds otherwise.
// tick is combinational and high during the last cycle of each slot.
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  output logic [$clog2(PRESCALE)-1:0] cnt,
  output logic                        tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST_CNT);
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with leading-zero blanking.
// Outputs registered one cycle after (cnt, idx, shadow); load is always accepted.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] valor,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [3:0]            dado,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   anodo
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] ALL_OFF  = '1;
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);
  localparam logic [CW-1:0]       DEAD_C   = CW'(DEAD);
  localparam logic [IW-1:0]       LAST_IDX = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic                    tick;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
  logic [N_DIGITS-1:0]     mask_q, mask_d;
  logic [3:0]              dado_q, dado_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     anodo_q, anodo_d;
  logic [4*MAX_DIGITS-1:0] value_ext;
  logic [MAX_DIGITS-1:0]   mask_ext;
  logic                    blank_cur;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .cnt    (cnt),
    .tick   (tick)
  );

  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    if (load) begin
      shadow_d = valor;
      mask_d   = dp_mask;
    end
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Dead time at the start of every slot keeps the previous digit's segments
  // from ghosting onto the next anode while the decoder settles.
  always_comb begin
    value_ext = (4*MAX_DIGITS)'(shadow_q);
    mask_ext  = MAX_DIGITS'(mask_q);
    blank_cur = (BLANK_LZ != 0) && f_digit_blank(value_ext, mask_ext, int'(idx_q));
    dado_d    = shadow_q[4*idx_q +: 4];
    dp_d      = ~mask_q[idx_q];
    anodo_d   = ALL_OFF;
    if (enable && (cnt >= DEAD_C) && !blank_cur) begin
      anodo_d = ~(ONE_HOT0 << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      shadow_q <= '0;
      mask_q   <= '0;
      dado_q   <= 4'h0;
      dp_q     <= 1'b1;
      anodo_q  <= ALL_OFF;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      dado_q   <= dado_d;
      dp_q     <= dp_d;
      anodo_q  <= anodo_d;
    end
  end

  assign dado  = dado_q;
  assign dp    = dp_q;
  assign anodo = anodo_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: per-pattern slot tables plus freeze, load-timing and reset sequences.
module tb_display_scan_mux;
  import display_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] valor = 16'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  dado;
  logic        dp;
  logic [3:0]  anodo;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_mux #(.N_DIGITS(4), .PRESCALE(8), .DEAD(2), .BLANK_LZ(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (load),
    .valor   (valor),
    .dp_mask (dp_mask),
    .dado    (dado),
    .dp      (dp),
    .anodo   (anodo)
  );

  always #5 clk = ~clk;

  // Per-slot expectations, packed as {slot3, slot2, slot1, slot0}.
  typedef struct {
    logic [15:0]      valor;
    logic [3:0]       mask;
    logic [3:0][3:0]  an;
    logic [3:0][3:0]  dd;
    logic [3:0]       dpx;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] an_e, input logic [3:0] dd_e,
                           input logic dp_e);
    check({tag, ".anodo"}, 16'(anodo), 16'(an_e));
    check({tag, ".dado"},  16'(dado),  16'(dd_e));
    check({tag, ".dp"},    16'(dp),    16'(dp_e));
  endtask

  // Reset, then load and enable together; after the next edge cnt=1, idx=0.
  task automatic start_pattern(input logic [15:0] v, input logic [3:0] m);
    rst_n = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    valor = v;
    dp_mask = m;
    load = 1'b1;
    enable = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h12A4, 4'b0000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {4'h1, 4'h2, 4'hA, 4'h4}, 4'b1111};
    vecs[1] = '{16'h0030, 4'b0000, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {4'h0, 4'h0, 4'h3, 4'h0}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {4'h0, 4'h0, 4'h0, 4'h0}, 4'b1111};
    vecs[3] = '{16'h0005, 4'b0100, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {4'h0, 4'h0, 4'h0, 4'h5}, 4'b1011};
    vecs[4] = '{16'h0F00, 4'b1000, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {4'h0, 4'hF, 4'h0, 4'h0}, 4'b0111};

    // Asynchronous reset between edges, before any clock has arrived.
    #2 rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'b1111, 4'h0, 1'b1);
    step();
    step();
    rst_n = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("idle_after_reset[%0d]", k), 4'b1111, 4'h0, 1'b1);
    end

    // Output after edge k reflects cnt=(k-1)%8 and slot=(k-1)/8.
    for (int r = 0; r < 5; r++) begin
      start_pattern(vecs[r].valor, vecs[r].mask);
      for (int k = 2; k <= 33; k++) begin
        int c;
        int s;
        logic [3:0] an_e;
        step();
        c = (k - 1) % 8;
        s = ((k - 1) / 8) % 4;
        an_e = (c < 2) ? 4'b1111 : vecs[r].an[s];
        check_out($sformatf("row%0d_k%0d", r, k), an_e, vecs[r].dd[s], vecs[r].dpx[s]);
      end
    end

    // Freeze at slot 1, cnt 4 (reached after edge 12).
    start_pattern(16'h12A4, 4'b0000);
    for (int k = 2; k <= 12; k++) step();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_out($sformatf("frozen[%0d]", k), 4'b1111, 4'hA, 1'b1);
    end
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_out($sformatf("resume_slot1[%0d]", k), 4'b1101, 4'hA, 1'b1);
    end
    step();
    check_out("resume_slot2_c0", 4'b1111, 4'h2, 1'b1);
    step();
    check_out("resume_slot2_c1", 4'b1111, 4'h2, 1'b1);
    step();
    check_out("resume_slot2_c2", 4'b1011, 4'h2, 1'b1);

    // Load in the last cycle of slot 0 (cnt 7 after edge 7).
    start_pattern(16'h12A4, 4'b0000);
    for (int k = 2; k <= 7; k++) step();
    valor = 16'hFFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    check_out("load_edge_old_data", 4'b1110, 4'h4, 1'b1);
    step();
    check_out("load_slot1_c0", 4'b1111, 4'hF, 1'b1);
    step();
    check_out("load_slot1_c1", 4'b1111, 4'hF, 1'b1);
    step();
    check_out("load_slot1_c2", 4'b1101, 4'hF, 1'b1);

    // Mid-operation reset, asserted between edges.
    #3 rst_n = 1'b0;
    #1;
    check_out("midop_reset", 4'b1111, 4'h0, 1'b1);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_out("midop_after_release", 4'b1111, 4'h0, 1'b1);
    enable = 1'b1;
    step();
    step();
    step();
    check_out("midop_rescan_c2", 4'b1110, 4'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
